// File: rtl/teng_pcs_pkg.sv
// Shared constants and types for the 10GBASE-R 64b/66b encoder.
package teng_pcs_pkg;

  localparam logic [1:0] HDR_DATA = 2'b10;
  localparam logic [1:0] HDR_CTRL = 2'b01;

  localparam logic [7:0] BT_IDLE = 8'h1E;
  localparam logic [7:0] BT_S0   = 8'h78;
  localparam logic [7:0] BT_S4   = 8'h33;
  // Block type for a terminate in lane k
  localparam logic [7:0] BT_T [0:7] = '{8'h87, 8'h99, 8'hAA, 8'hB4,
                                        8'hCC, 8'hD2, 8'hE1, 8'hFF};

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;

  localparam logic [6:0] CTL_IDLE = 7'h00;
  localparam logic [6:0] CTL_ERR  = 7'h1E;

  localparam logic [63:0] BLK_IDLE = {{8{CTL_IDLE}}, BT_IDLE};
  localparam logic [63:0] BLK_ERR  = {{8{CTL_ERR}}, BT_IDLE};

  typedef enum logic [2:0] {CLS_C, CLS_S0, CLS_S4, CLS_D, CLS_T, CLS_E} blk_class_t;
  typedef enum logic [1:0] {ST_C, ST_D, ST_E} enc_state_t;

endpackage

// File: rtl/teng_64b66b_blk_classify.sv
// Combinational classifier: maps one XGMII word to a block class plus terminate lane.
module teng_64b66b_blk_classify
  import teng_pcs_pkg::*;
(
  input  logic [63:0] txd_i,
  input  logic [7:0]  txc_i,
  output blk_class_t  cls_o,
  output logic [2:0]  term_lane_o
);

  logic [7:0] idle_lane;
  logic [7:0] t_mask;
  logic [7:0] hi_mask;

  // Flag each lane that carries the idle character
  always_comb begin
    idle_lane = '0;
    for (int i = 0; i < 8; i++) begin
      idle_lane[i] = (txd_i[8*i +: 8] == XGMII_IDLE);
    end
  end

  // Decode the word; terminate forms are mutually exclusive because txc differs per lane
  always_comb begin
    cls_o       = CLS_E;
    term_lane_o = '0;
    t_mask      = '0;
    hi_mask     = '0;
    if (txc_i == 8'h00) begin
      cls_o = CLS_D;
    end else if (txc_i == 8'hFF && idle_lane == 8'hFF) begin
      cls_o = CLS_C;
    end else if (txc_i == 8'h01 && txd_i[7:0] == XGMII_START) begin
      cls_o = CLS_S0;
    end else if (txc_i == 8'h1F && idle_lane[3:0] == 4'hF && txd_i[39:32] == XGMII_START) begin
      cls_o = CLS_S4;
    end else begin
      for (int k = 0; k < 8; k++) begin
        t_mask  = 8'hFF << k;
        hi_mask = t_mask << 1;
        if (txc_i == t_mask && txd_i[8*k +: 8] == XGMII_TERM &&
            (idle_lane & hi_mask) == hi_mask) begin
          cls_o       = CLS_T;
          term_lane_o = 3'(k);
        end
      end
    end
  end

endmodule

// File: rtl/teng_64b66b_encode.sv
// XGMII TX to 64b/66b block encoder with C/D/T/E sequencing.
// Define ENCODE_ERR_CNT_EN to add the saturating error-block counter (err_cnt_o).
module teng_64b66b_encode
  import teng_pcs_pkg::*;
`ifdef ENCODE_ERR_CNT_EN
#(
  parameter int unsigned ERR_CNT_W = 16
)
`endif
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] xgmii_txd_i,
  input  logic [7:0]  xgmii_txc_i,
  input  logic        xgmii_txd_vld_i,
  output logic [63:0] encode_data_o,
  output logic [1:0]  encode_head_o,
  output logic        encode_data_vld_o,
  output logic        encode_error_o
`ifdef ENCODE_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

  blk_class_t  cls;
  logic [2:0]  term_lane;
  logic [63:0] cls_payload;
  logic        legal;
  enc_state_t  state_q, state_d, state_nxt;
  logic [63:0] data_q, data_d;
  logic [1:0]  head_q, head_d;
  logic        vld_q, vld_d;
  logic        error_q, error_d;

  teng_64b66b_blk_classify u_classify (
    .txd_i       (xgmii_txd_i),
    .txc_i       (xgmii_txc_i),
    .cls_o       (cls),
    .term_lane_o (term_lane)
  );

  // Payload the current word would produce if the sequence allows it
  always_comb begin
    cls_payload = BLK_ERR;
    case (cls)
      CLS_D:  cls_payload = xgmii_txd_i;
      CLS_C:  cls_payload = BLK_IDLE;
      CLS_S0: cls_payload = {xgmii_txd_i[63:8], BT_S0};
      CLS_S4: cls_payload = {xgmii_txd_i[63:40], 4'h0, 28'h0, BT_S4};
      CLS_T: begin
        cls_payload      = '0;
        cls_payload[7:0] = BT_T[term_lane];
        for (int i = 0; i < 7; i++) begin
          if (i < int'(term_lane)) cls_payload[8*i+8 +: 8] = xgmii_txd_i[8*i +: 8];
        end
      end
      default: cls_payload = BLK_ERR;
    endcase
  end

  // Sequencing rules: ST_C and ST_E accept C or S; ST_D accepts D or T
  always_comb begin
    legal     = 1'b0;
    state_nxt = ST_E;
    case (state_q)
      ST_D: begin
        if (cls == CLS_D) begin
          legal     = 1'b1;
          state_nxt = ST_D;
        end else if (cls == CLS_T) begin
          legal     = 1'b1;
          state_nxt = ST_C;
        end
      end
      default: begin
        if (cls == CLS_C) begin
          legal     = 1'b1;
          state_nxt = ST_C;
        end else if (cls == CLS_S0 || cls == CLS_S4) begin
          legal     = 1'b1;
          state_nxt = ST_D;
        end
      end
    endcase
  end

  // Next-state for FSM and output registers; everything but vld holds on a paused word
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    head_d  = head_q;
    error_d = error_q;
    vld_d   = xgmii_txd_vld_i;
    if (xgmii_txd_vld_i) begin
      state_d = state_nxt;
      data_d  = legal ? cls_payload : BLK_ERR;
      head_d  = (legal && cls == CLS_D) ? HDR_DATA : HDR_CTRL;
      error_d = !legal;
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_C;
      data_q  <= '0;
      head_q  <= HDR_CTRL;
      vld_q   <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      head_q  <= head_d;
      vld_q   <= vld_d;
      error_q <= error_d;
    end
  end

  assign encode_data_o     = data_q;
  assign encode_head_o     = head_q;
  assign encode_data_vld_o = vld_q;
  assign encode_error_o    = error_q;

`ifdef ENCODE_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Count emitted E blocks, saturating at all-ones
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (xgmii_txd_vld_i && !legal && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
  end

  // Counter register, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) err_cnt_q <= '0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`else
  // No error counter in this build; E blocks are still flagged on encode_error_o.
`endif

endmodule
